// File: rtl/dma_buf_arb_pkg.sv
// Shared types for the DMA stream buffer arbiter.
//  buf_arb_state_t : ownership state of the single-entry buffer
//  prio_t          : 2-bit per-stream priority level (3 = highest)
package dma_buf_arb_pkg;

  typedef enum logic [1:0] {
    BA_IDLE  = 2'd0,
    BA_EMPTY = 2'd1,
    BA_FULL  = 2'd2
  } buf_arb_state_t;

  typedef logic [1:0] prio_t;

  localparam prio_t PRIO_MAX = 2'd3;

endpackage

// File: rtl/dma_buf_arb_if.sv
// Bus bundle between the stream channel FSMs / AHB master and the buffer arbiter.
//  i_req/i_prio      : per-stream ownership request and priority level
//  i_put/i_wdata     : source-side beat write (owner only)
//  i_pull            : destination-side beat consumed
//  o_gnt/o_gnt_id    : one-hot and binary owner (0 when idle)
//  o_busy/o_full     : buffer owned / buffer holds an unread beat
//  o_rdata           : buffer contents
//  o_done/o_flush    : one-cycle pulses after a normal pull / forced discard
// slave modport faces the arbiter, master modport faces the requesters.
interface dma_buf_arb_if #(
  parameter int nstream = 8,
  parameter int wbus    = 32
);
  logic [nstream-1:0]         i_req;
  logic [2*nstream-1:0]       i_prio;
  logic                       i_put;
  logic [wbus-1:0]            i_wdata;
  logic                       i_pull;
  logic [nstream-1:0]         o_gnt;
  logic [$clog2(nstream)-1:0] o_gnt_id;
  logic                       o_busy;
  logic [wbus-1:0]            o_rdata;
  logic                       o_full;
  logic                       o_done;
  logic                       o_flush;

  modport slave (
    input  i_req, i_prio, i_put, i_wdata, i_pull,
    output o_gnt, o_gnt_id, o_busy, o_rdata, o_full, o_done, o_flush
  );

  modport master (
    output i_req, i_prio, i_put, i_wdata, i_pull,
    input  o_gnt, o_gnt_id, o_busy, o_rdata, o_full, o_done, o_flush
  );
endinterface

// File: rtl/dma_buf_reg.sv
// Single-entry stream data buffer.
//  i_clk    : clock (posedge)
//  i_nreset : asynchronous active-low reset
//  i_put    : capture i_wdata and mark full
//  i_wdata  : beat data
//  i_pull   : mark empty (data is kept)
//  o_rdata  : held beat, stable until the next put
//  o_full   : buffer holds an unread beat
module dma_buf_reg #(
  parameter int wbus = 32
) (
  input  logic            i_clk,
  input  logic            i_nreset,
  input  logic            i_put,
  input  logic [wbus-1:0] i_wdata,
  input  logic            i_pull,
  output logic [wbus-1:0] o_rdata,
  output logic            o_full
);

  logic [wbus-1:0] data_q;
  logic            full_q;

  // Put has precedence; the arbiter never issues both in the same cycle.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (i_put) begin
      data_q <= i_wdata;
      full_q <= 1'b1;
    end else if (i_pull) begin
      full_q <= 1'b0;
    end
  end

  assign o_rdata = data_q;
  assign o_full  = full_q;

endmodule

// File: rtl/dma_buf_arb.sv
// Arbitrates ownership of the single-entry stream buffer among nstream DMA
// streams: highest priority level wins, round-robin among equal levels.
// The owner gets exactly one beat (put then pull) before re-arbitration.
//  i_clk   : clock (posedge)
//  i_reset : asynchronous active-high reset
//  bus     : dma_buf_arb_if slave modport (requests, beat data, grant/status)
module dma_buf_arb
  import dma_buf_arb_pkg::*;
#(
  parameter int nstream = 8,
  parameter int wbus    = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  dma_buf_arb_if.slave  bus
);

  localparam int IDW = $clog2(nstream);
  typedef logic [IDW-1:0] id_t;

  buf_arb_state_t     state_q, state_d;
  logic [nstream-1:0] gnt_q, gnt_d;
  id_t                gnt_id_q, gnt_id_d;
  id_t                rr_q, rr_d;
  logic               done_q, done_d;
  logic               flush_q, flush_d;
  logic               buf_put, buf_pull;
  logic               owner_req;
  id_t                win;

  // Masked-priority round-robin: find the top level among requesters, then
  // take the first requester at that level scanning from rr+1 with wrap.
  function automatic id_t pick_winner(input logic [nstream-1:0]   req,
                                      input logic [2*nstream-1:0] prio,
                                      input id_t                  rr);
    prio_t top;
    logic  seen;
    id_t   sel;
    int    idx;
    top  = '0;
    seen = 1'b0;
    sel  = '0;
    for (int k = 0; k < nstream; k++) begin
      if (top != PRIO_MAX && req[k] && prio[2*k +: 2] > top) top = prio[2*k +: 2];
    end
    for (int off = 1; off <= nstream; off++) begin
      idx = (int'(rr) + off) % nstream;
      if (!seen && req[idx] && prio[2*idx +: 2] == top) begin
        sel  = id_t'(idx);
        seen = 1'b1;
      end
    end
    return sel;
  endfunction

  assign win       = pick_winner(bus.i_req, bus.i_prio, rr_q);
  assign owner_req = bus.i_req[gnt_id_q];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    rr_d     = rr_q;
    done_d   = 1'b0;
    flush_d  = 1'b0;
    buf_put  = 1'b0;
    buf_pull = 1'b0;
    unique case (state_q)
      BA_IDLE: begin
        if (|bus.i_req) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          gnt_id_d   = win;
          rr_d       = win;
          state_d    = BA_EMPTY;
        end
      end
      BA_EMPTY: begin
        // A pull here has nothing to consume and is ignored.
        if (bus.i_put && owner_req) begin
          buf_put = 1'b1;
          state_d = BA_FULL;
        end else if (!owner_req) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          state_d  = BA_IDLE;
        end
      end
      BA_FULL: begin
        // A real pull beats a simultaneous request drop: done, not flush.
        if (bus.i_pull) begin
          buf_pull = 1'b1;
          done_d   = 1'b1;
          gnt_d    = '0;
          gnt_id_d = '0;
          state_d  = BA_IDLE;
        end else if (!owner_req) begin
          buf_pull = 1'b1;
          flush_d  = 1'b1;
          gnt_d    = '0;
          gnt_id_d = '0;
          state_d  = BA_IDLE;
        end
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = BA_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= BA_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      rr_q     <= id_t'(nstream - 1);
      done_q   <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rr_q     <= rr_d;
      done_q   <= done_d;
      flush_q  <= flush_d;
    end
  end

  dma_buf_reg #(.wbus(wbus)) u_buf (
    .i_clk    (i_clk),
    .i_nreset (~i_reset),
    .i_put    (buf_put),
    .i_wdata  (bus.i_wdata),
    .i_pull   (buf_pull),
    .o_rdata  (bus.o_rdata),
    .o_full   (bus.o_full)
  );

  assign bus.o_gnt    = gnt_q;
  assign bus.o_gnt_id = gnt_id_q;
  assign bus.o_busy   = (state_q != BA_IDLE);
  assign bus.o_done   = done_q;
  assign bus.o_flush  = flush_q;

endmodule
